// File: rtl/instr_fetch.sv
// Instruction-fetch stage: program counter, synchronous instruction-memory requests,
// and a 2-entry {pc, instruction} FIFO handing instructions to the decoder.

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    logic [31:0] fetch_pc_r;
    logic        inflight_valid_r;
    logic [31:0] inflight_pc_r;

    logic [31:0] fifo_pc_r    [2];
    logic [31:0] fifo_instr_r [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;

    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic [2:0]  occupancy_s;

    // Handshake and issue decisions; occupancy counts slots already promised to the FIFO.
    always_comb begin
        pop_s       = 1'b0;
        push_s      = 1'b0;
        issue_s     = 1'b0;
        occupancy_s = 3'd0;
        pop_s       = (count_r != 2'd0) && instr_ready;
        push_s      = inflight_valid_r && !redirect_valid;
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_valid_r} - {2'b00, pop_s};
        if (rst_n && !redirect_valid && (occupancy_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign imem_req    = issue_s;
    assign imem_addr   = fetch_pc_r;
    assign instr_valid = (count_r != 2'd0);
    assign instruction = fifo_instr_r[rd_ptr_r];
    assign pc_out      = fifo_pc_r[rd_ptr_r];

    // Program counter and the single outstanding memory request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r       <= RESET_PC;
            inflight_valid_r <= 1'b0;
            inflight_pc_r    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            fetch_pc_r       <= {redirect_pc[31:2], 2'b00};
            inflight_valid_r <= 1'b0;
        end else if (issue_s) begin
            fetch_pc_r       <= fetch_pc_r + 32'd4;
            inflight_valid_r <= 1'b1;
            inflight_pc_r    <= fetch_pc_r;
        end else begin
            inflight_valid_r <= 1'b0;
        end
    end

    // Output FIFO; a redirect drops everything not popped this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_pc_r[0]    <= 32'h0000_0000;
            fifo_pc_r[1]    <= 32'h0000_0000;
            fifo_instr_r[0] <= 32'h0000_0000;
            fifo_instr_r[1] <= 32'h0000_0000;
            rd_ptr_r        <= 1'b0;
            wr_ptr_r        <= 1'b0;
            count_r         <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
                fifo_instr_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r               <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    instr_fetch_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .count (count_r)
    );

endmodule

// Simulation checks for instr_fetch internal invariants.
module instr_fetch_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic [1:0] count
);

    // The issue rule must never let a response arrive while the FIFO is full.
    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count != 2'd2));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table plus a delivery scoreboard.

module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_valid2;
    logic        instr_ready;
    logic        ready2;
    logic        redir2;
    logic [31:0] rpc2;
    logic [31:0] instruction, instruction2;
    logic [31:0] pc_out, pc_out2;

    int n_vec;
    int n_err;
    int n_pop2;
    logic prog_mode;

    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .pc_out(pc_out)
    );

    instr_fetch #(.RESET_PC(RPC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(redir2), .redirect_pc(rpc2),
        .instr_valid(instr_valid2), .instr_ready(ready2), .instruction(instruction2),
        .pc_out(pc_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic m);
        if (m && a == 32'h0000_0000) return 32'h0020_80B3;
        if (m && a == 32'h0000_0004) return 32'h0020_80E3;
        return a;
    endfunction

    // Synchronous instruction memories: data one cycle after the request.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= mem_word(imem_addr, prog_mode);
        if (imem_req2) imem_rdata2 <= mem_word(imem_addr2, prog_mode);
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];

    function automatic void refill(inout exp_t q[$], input logic [31:0] start, input logic m);
        logic [31:0] p;
        q.delete();
        p = start;
        for (int k = 0; k < 40; k++) begin
            q.push_back({p, mem_word(p, m)});
            p = p + 32'd4;
        end
    endfunction

    // Scoreboard: each accepted instruction must be the next one of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            n_vec++;
            if (sb1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_empty: got pc=%h ins=%h, expected no delivery", pc_out, instruction);
            end else begin
                e = sb1.pop_front();
                if (pc_out !== e.pc || instruction !== e.ins) begin
                    n_err++;
                    $display("FAIL sb1_deliver: got pc=%h ins=%h, expected pc=%h ins=%h",
                             pc_out, instruction, e.pc, e.ins);
                end
            end
        end
        if (rst_n === 1'b1 && instr_valid2 === 1'b1 && ready2 === 1'b1) begin
            n_vec++;
            n_pop2++;
            if (sb2.size() == 0) begin
                n_err++;
                $display("FAIL sb2_empty: got pc=%h, expected no delivery", pc_out2);
            end else begin
                e = sb2.pop_front();
                if (pc_out2 !== e.pc || instruction2 !== e.ins) begin
                    n_err++;
                    $display("FAIL sb2_deliver: got pc=%h ins=%h, expected pc=%h ins=%h",
                             pc_out2, instruction2, e.pc, e.ins);
                end
            end
        end
        if (rst_n !== 1'b1) begin
            refill(sb1, 32'h0000_0000, prog_mode);
            refill(sb2, RPC2, prog_mode);
        end else if (redirect_valid === 1'b1) begin
            refill(sb1, {redirect_pc[31:2], 2'b00}, prog_mode);
        end
    end

    typedef struct packed {
        logic        rn;
        logic        rd;
        logic        rv;
        logic [31:0] rp;
        logic        ck;
        logic        dc;
        logic        rq;
        logic [31:0] ad;
        logic        vl;
        logic [31:0] p;
        logic [31:0] i;
    } vec_t;

    function automatic vec_t v(input logic rn, rd, rv, input logic [31:0] rp,
                               input logic ck, dc, rq, input logic [31:0] ad,
                               input logic vl, input logic [31:0] p, i);
        vec_t t;
        t.rn = rn; t.rd = rd; t.rv = rv; t.rp = rp; t.ck = ck; t.dc = dc;
        t.rq = rq; t.ad = ad; t.vl = vl; t.p = p; t.i = i;
        return t;
    endfunction

    vec_t tbl[31];

    initial begin
        n_vec = 0; n_err = 0; n_pop2 = 0;
        prog_mode = 1'b0;
        rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ready2 = 1'b1; redir2 = 1'b0; rpc2 = 32'h0;
        imem_rdata = 32'h0; imem_rdata2 = 32'h0;

        //            rn    rd    rv    rp            ck    dc    rq    addr          vl    pc            instr
        tbl[0]  = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0);
        tbl[1]  = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0);
        tbl[2]  = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0);
        tbl[3]  = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0);
        tbl[4]  = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h8,        1'b1, 32'h0,        32'h0);
        tbl[5]  = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC,        1'b1, 32'h4,        32'h4);
        tbl[6]  = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h10,       1'b1, 32'h8,        32'h8);
        for (int r = 7; r <= 11; r++)
            tbl[r] = v(1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h14,       1'b1, 32'hC,        32'hC);
        tbl[12] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h14,       1'b1, 32'hC,        32'hC);
        tbl[13] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h18,       1'b1, 32'h10,       32'h10);
        tbl[14] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h1C,       1'b1, 32'h14,       32'h14);
        tbl[15] = v(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h20,       1'b1, 32'h18,       32'h18);
        tbl[16] = v(1'b1, 1'b0, 1'b1, 32'h803,      1'b1, 1'b0, 1'b0, 32'h20,       1'b1, 32'h18,       32'h18);
        tbl[17] = v(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h800,      1'b0, 32'h0,        32'h0);
        tbl[18] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h804,      1'b0, 32'h0,        32'h0);
        tbl[19] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h808,      1'b1, 32'h800,      32'h800);
        tbl[20] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h80C,      1'b1, 32'h804,      32'h804);
        tbl[21] = v(1'b1, 1'b1, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 32'h810,      1'b1, 32'h808,      32'h808);
        tbl[22] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0);
        tbl[23] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h104,      1'b0, 32'h0,        32'h0);
        tbl[24] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h108,      1'b1, 32'h100,      32'h100);
        tbl[25] = v(1'b0, 1'b1, 1'b1, 32'h400,      1'b1, 1'b0, 1'b0, 32'h10C,      1'b1, 32'h104,      32'h104);
        tbl[26] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0);
        tbl[27] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0);
        tbl[28] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h8,        1'b1, 32'h0,        32'h0020_80B3);
        tbl[29] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC,        1'b1, 32'h4,        32'h0020_80E3);
        tbl[30] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h10,       1'b1, 32'h8,        32'h8);

        for (int r = 0; r < 31; r++) begin
            @(posedge clk);
            #1;
            rst_n          = tbl[r].rn;
            instr_ready    = tbl[r].rd;
            redirect_valid = tbl[r].rv;
            redirect_pc    = tbl[r].rp;
            prog_mode      = (r >= 25);
            #1;
            if (tbl[r].ck) begin
                n_vec++;
                if (imem_req !== tbl[r].rq || imem_addr !== tbl[r].ad || instr_valid !== tbl[r].vl ||
                    ((tbl[r].vl || tbl[r].dc) && (pc_out !== tbl[r].p || instruction !== tbl[r].i))) begin
                    n_err++;
                    $display("FAIL row%0d: got req=%b addr=%h valid=%b pc=%h ins=%h, expected req=%b addr=%h valid=%b pc=%h ins=%h",
                             r, imem_req, imem_addr, instr_valid, pc_out, instruction,
                             tbl[r].rq, tbl[r].ad, tbl[r].vl, tbl[r].p, tbl[r].i);
                end
            end
        end

        // Let the stream run a little longer under the scoreboard, then quiesce.
        repeat (6) @(posedge clk);
        #1;
        instr_ready = 1'b0;
        ready2      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (n_pop2 < 12) begin
            n_err++;
            $display("FAIL dut2_deliveries: got %0d, expected at least 12", n_pop2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 32-bit RISC-V core, directly upstream of the decoder. Holds the program counter, issues word reads to a synchronous instruction memory, and delivers each returned 32-bit instruction with its PC to the decoder through a valid/ready handshake. A 2-entry output FIFO decouples memory latency from decoder back-pressure. Branch/jump redirects from later stages flush in-flight work and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset (word aligned).
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  32  byte address of the request; bits [1:0] always 0.
- imem_rdata  in  32  read data, valid exactly one cycle after the accepted request; memory always accepts.
- redirect_valid  in  1  taken branch/jump; restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decoder accepts head this cycle.
- instruction  out  32  FIFO head instruction (to decoder instruction input).
- pc_out  out  32  byte address of the head instruction.

## Operation
- State: fetch_pc (32), inflight_valid + inflight_pc (request issued last cycle), 2-entry FIFO of {pc, instruction} with count 0..2.
- pop = instr_valid && instr_ready. push = inflight_valid && !redirect_valid (imem_rdata paired with inflight_pc).
- issue = rst_n && !redirect_valid && (count + inflight_valid - pop) < 2. When issue: imem_req=1, imem_addr=fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), inflight_valid <= 1, inflight_pc <= fetch_pc. Otherwise inflight_valid <= 0.
- imem_addr = fetch_pc in every cycle (also when imem_req=0).
- Redirect (priority over everything except reset): FIFO count <= 0, inflight_valid <= 0 (response arriving next cycle discarded), fetch_pc <= {redirect_pc[31:2],2'b00}, imem_req=0 that cycle. A pop in the same cycle still completes (decoder keeps that instruction); all other entries dropped.
- FIFO: first-in first-out; push and pop in same cycle allowed at any count; push never occurs when full (guaranteed by issue rule—assert in simulation).
- instr_valid = (count != 0); instruction/pc_out = head entry; hold stable while instr_valid && !instr_ready.
- No decode of instruction contents; illegal encodings are passed through.

## Timing
- Reset (rst_n=0 at edge): fetch_pc=RESET_PC, count=0, inflight_valid=0; outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, pc_out=0.
- First cycle with rst_n=1: imem_req=1, imem_addr=RESET_PC. Data arrives next cycle, pushed at that edge; instr_valid=1 one cycle later (issue-to-valid latency 2 cycles).
- Steady state with instr_ready=1: one instruction per cycle, consecutive PCs +4.
- instr_ready=0: FIFO fills to 2 with at most one issue beyond the first entry; issue stops; resumes in the same cycle as the first pop.
- Redirect at cycle N: imem_addr=target with imem_req=1 at N+1; instr_valid for target at N+3; instr_valid=0 at N+1 and N+2.
- Reset asserted mid-operation: all state cleared at that edge regardless of redirect/handshake; memory response arriving after reset is ignored.

## Test plan
- Reset release, RESET_PC=0, instr_ready=1, memory returns word = address: imem_addr 0,4,8,... on consecutive cycles; instr_valid rises 2 cycles after release; pc_out 0,4,8 with instruction 0,4,8 one per cycle.
- Memory holds 0x002080B3 (add x1,x1,x2) at 0x0, 0x002080E3 (beq) at 0x4: instruction/pc_out present {0x002080B3,0},{0x002080E3,4} in order.
- instr_ready=0 for 5 cycles after first valid: count saturates at 2, imem_req drops to 0, head stays {pc 0}; release ready: pcs 0,4,8,... with no gap or duplicate.
- redirect_valid one cycle with redirect_pc=0x0000_0803 while FIFO full: FIFO flushed, next imem_addr=0x800, next delivered pc_out=0x800, no stale pc delivered.
- RESET_PC=0xFFFF_FFF8: pc_out sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n low for one cycle mid-stream with redirect_valid=1 same cycle: instr_valid=0 next cycle, fetch restarts at RESET_PC, not redirect target.
